// File: rtl/revcnt_pkg.sv
// Shared types and constants for the revcnt sequencer and its counter core.
package revcnt_pkg;

  localparam int REVCNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ONESHOT  = 2'd0,
    RELOAD   = 2'd1,
    PINGPONG = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The reserved encoding 3 behaves as one-shot.
  function automatic mode_t to_mode(input logic [1:0] m);
    return (m == 2'd3) ? ONESHOT : mode_t'(m);
  endfunction

endpackage

// File: rtl/revcnt_core.sv
// WIDTH-bit reversible counter register: load has priority over the enabled step.
module revcnt_core
  import revcnt_pkg::*;
#(
  parameter int WIDTH = REVCNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= up ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
    end
  end

endmodule

// File: rtl/revcnt_seq.sv
// Sequencer around revcnt_core: one-shot, auto-reload and ping-pong modes.
// Optional REVCNT_PAUSE_EN adds the pause input.
module revcnt_seq
  import revcnt_pkg::*;
#(
  parameter int WIDTH = REVCNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
`ifdef REVCNT_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [1:0]       mode,
  input  logic             dir_init,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] lim_val,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  logic pause_i;
`ifdef REVCNT_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  state_t           state, state_n;
  mode_t            mode_r;
  logic [WIDTH-1:0] load_r, lim_r;
  logic             dir_r;
  logic             dir_n;
  logic             latch;
  logic             core_en, core_load, core_up;
  logic [WIDTH-1:0] core_val;
  logic             at_t, step;

  assign at_t = dir ? (cnt == lim_r) : (cnt == '0);
  assign step = (state == RUN) && !pause_i;
  assign tc   = step && at_t;
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_n   = state;
    dir_n     = dir;
    latch     = 1'b0;
    core_en   = 1'b0;
    core_load = 1'b0;
    core_up   = dir;
    core_val  = load_r;
    if (stop) begin
      state_n = IDLE;
    end else if (start) begin
      latch     = 1'b1;
      core_load = 1'b1;
      core_val  = load_val;
      dir_n     = dir_init;
      state_n   = RUN;
    end else if (step) begin
      if (!at_t) begin
        core_en = 1'b1;
      end else begin
        case (mode_r)
          RELOAD: begin
            core_load = 1'b1;
            dir_n     = dir_r;
          end
          PINGPONG: begin
            // With lim_r == 0 both terminals coincide, so the count parks at 0.
            if (lim_r != '0) begin
              dir_n   = !dir;
              core_en = 1'b1;
              core_up = !dir;
            end
          end
          default: state_n = DONE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      dir    <= 1'b1;
      mode_r <= ONESHOT;
      load_r <= '0;
      lim_r  <= '0;
      dir_r  <= 1'b0;
    end else begin
      state <= state_n;
      dir   <= dir_n;
      if (latch) begin
        mode_r <= to_mode(mode);
        load_r <= load_val;
        lim_r  <= lim_val;
        dir_r  <= dir_init;
      end
    end
  end

  revcnt_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (core_en),
    .load     (core_load),
    .load_val (core_val),
    .up       (core_up),
    .cnt      (cnt)
  );

endmodule

// File: tb/tb_revcnt_seq.sv
// Directed, table-driven bench for revcnt_seq with a few hand-written sequences.
module tb_revcnt_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        dir_init = 1'b1;
  logic [15:0] load_val = '0;
  logic [15:0] lim_val = '0;
  logic [15:0] cnt;
  logic        dir, busy, done, tc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  revcnt_seq #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
`ifdef REVCNT_PAUSE_EN
    .pause    (pause),
`endif
    .mode     (mode),
    .dir_init (dir_init),
    .load_val (load_val),
    .lim_val  (lim_val),
    .cnt      (cnt),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .tc       (tc)
  );

  typedef struct {
    logic        rst_n, start, stop;
    logic [1:0]  mode;
    logic        dir_init;
    logic [15:0] load_val, lim_val;
    logic [15:0] e_cnt;
    logic        e_dir, e_busy, e_done, e_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic p, input logic [1:0] m,
                     input logic d, input logic [15:0] lv, input logic [15:0] lm,
                     input logic [15:0] ec, input logic ed, input logic eb,
                     input logic edn, input logic et);
    vec_t v;
    v.rst_n = r; v.start = s; v.stop = p; v.mode = m; v.dir_init = d;
    v.load_val = lv; v.lim_val = lm;
    v.e_cnt = ec; v.e_dir = ed; v.e_busy = eb; v.e_done = edn; v.e_tc = et;
    vecs.push_back(v);
  endtask

  // Idle cycle (no control), only expectations given.
  task automatic idle(input logic [15:0] ec, input logic ed, input logic eb,
                      input logic edn, input logic et);
    add(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0, ec, ed, eb, edn, et);
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx, input logic [15:0] ec,
                            input logic ed, input logic eb, input logic edn,
                            input logic et);
    check({tag, ".cnt"}, idx, cnt, ec);
    check({tag, ".dir"}, idx, 16'(dir), 16'(ed));
    check({tag, ".busy"}, idx, 16'(busy), 16'(eb));
    check({tag, ".done"}, idx, 16'(done), 16'(edn));
    check({tag, ".tc"}, idx, 16'(tc), 16'(et));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;

    // Reset
    add(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 16'd0, 1, 0, 0, 0);
    idle(16'd0, 1, 0, 0, 0);
    // One-shot up, 3 -> 7
    add(1, 1, 0, 2'd0, 1, 16'd3, 16'd7, 16'd3, 1, 1, 0, 0);
    idle(16'd4, 1, 1, 0, 0);
    idle(16'd5, 1, 1, 0, 0);
    idle(16'd6, 1, 1, 0, 0);
    idle(16'd7, 1, 1, 0, 1);
    idle(16'd7, 1, 0, 1, 0);
    idle(16'd7, 1, 0, 1, 0);
    // Stop from DONE
    add(1, 0, 1, 2'd0, 0, 16'h0, 16'h0, 16'd7, 1, 0, 0, 0);
    // Auto-reload down from 2
    add(1, 1, 0, 2'd1, 0, 16'd2, 16'd9, 16'd2, 0, 1, 0, 0);
    idle(16'd1, 0, 1, 0, 0);
    idle(16'd0, 0, 1, 0, 1);
    idle(16'd2, 0, 1, 0, 0);
    idle(16'd1, 0, 1, 0, 0);
    idle(16'd0, 0, 1, 0, 1);
    idle(16'd2, 0, 1, 0, 0);
    // Ping-pong 0..3
    add(1, 1, 0, 2'd2, 1, 16'd0, 16'd3, 16'd0, 1, 1, 0, 0);
    idle(16'd1, 1, 1, 0, 0);
    idle(16'd2, 1, 1, 0, 0);
    idle(16'd3, 1, 1, 0, 1);
    idle(16'd2, 0, 1, 0, 0);
    idle(16'd1, 0, 1, 0, 0);
    idle(16'd0, 0, 1, 0, 1);
    idle(16'd1, 1, 1, 0, 0);
    idle(16'd2, 1, 1, 0, 0);
    // Up wrap FFFE -> 0001, one-shot
    add(1, 1, 0, 2'd0, 1, 16'hFFFE, 16'd1, 16'hFFFE, 1, 1, 0, 0);
    idle(16'hFFFF, 1, 1, 0, 0);
    idle(16'h0000, 1, 1, 0, 0);
    idle(16'h0001, 1, 1, 0, 1);
    idle(16'h0001, 1, 0, 1, 0);
    // Degenerate ping-pong lim 0
    add(1, 1, 0, 2'd2, 1, 16'd0, 16'd0, 16'd0, 1, 1, 0, 1);
    idle(16'd0, 1, 1, 0, 1);
    idle(16'd0, 1, 1, 0, 1);
    // Reserved mode 3 as one-shot, start already terminal
    add(1, 1, 0, 2'd3, 1, 16'd2, 16'd2, 16'd2, 1, 1, 0, 1);
    idle(16'd2, 1, 0, 1, 0);
    // Restart in RUN, then stop+start together
    add(1, 1, 0, 2'd0, 1, 16'd10, 16'd20, 16'd10, 1, 1, 0, 0);
    idle(16'd11, 1, 1, 0, 0);
    add(1, 1, 0, 2'd0, 1, 16'd40, 16'd50, 16'd40, 1, 1, 0, 0);
    idle(16'd41, 1, 1, 0, 0);
    add(1, 1, 1, 2'd1, 0, 16'd100, 16'd200, 16'd41, 1, 0, 0, 0);
    idle(16'd41, 1, 0, 0, 0);
    // Reset mid-run with dir down
    add(1, 1, 0, 2'd0, 0, 16'd10, 16'd20, 16'd10, 0, 1, 0, 0);
    idle(16'd9, 0, 1, 0, 0);
    add(0, 0, 0, 2'd0, 0, 16'd0, 16'd0, 16'd0, 1, 0, 0, 0);
    idle(16'd0, 1, 0, 0, 0);

    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n    = vecs[i].rst_n;
      start    = vecs[i].start;
      stop     = vecs[i].stop;
      mode     = vecs[i].mode;
      dir_init = vecs[i].dir_init;
      load_val = vecs[i].load_val;
      lim_val  = vecs[i].lim_val;
      tick();
      check_outs("vec", i, vecs[i].e_cnt, vecs[i].e_dir, vecs[i].e_busy,
                 vecs[i].e_done, vecs[i].e_tc);
    end
    start = 1'b0;
    stop  = 1'b0;
    rst_n = 1'b1;

    // Long one-shot: 0 -> 300 reaches DONE 301 edges after start
    start = 1'b1; mode = 2'd0; dir_init = 1'b1; load_val = 16'd0; lim_val = 16'd300;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    check("long.edges", 0, 16'(n), 16'd301);
    check("long.cnt", 0, cnt, 16'd300);

`ifdef REVCNT_PAUSE_EN
    // Pause held three cycles at cnt 5
    start = 1'b1; mode = 2'd0; dir_init = 1'b1; load_val = 16'd3; lim_val = 16'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pause.pre", 0, cnt, 16'd5);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("pause.tc", k, 16'(tc), 16'd0);
      tick();
      check("pause.cnt", k, cnt, 16'd5);
      check("pause.busy", k, 16'(busy), 16'd1);
    end
    pause = 1'b0;
    tick();
    check("pause.resume", 0, cnt, 16'd6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
